// File: rtl/mem_responder.sv
// Word-addressed memory responder with an IDLE/WAIT/XFER handshake.
// Serves single or burst reads and writes, inserting WAIT_STATES idle cycles before every beat.
module mem_responder #(
   parameter int WAIT_STATES = 1,
   parameter int ADDR_BITS   = 8
) (
   input  logic        clk,
   input  logic        proc_rst,
   input  logic        memread,
   input  logic        memwrite,
   input  logic [15:0] addr,
   input  logic [15:0] mem_wdata,
   input  logic [2:0]  burst_len,
   output logic        ready,
   output logic        beat_ack,
   output logic        last,
   output logic [15:0] rdata,
   output logic        rdata_valid,
   output logic        err
);

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_XFER} state_t;

   localparam int         DEPTH     = 1 << ADDR_BITS;
   localparam logic [2:0] WAIT_LOAD = 3'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);

   state_t               state_q, state_d;
   logic [2:0]           wait_cnt_q, wait_cnt_d;
   logic [2:0]           beat_q, beat_d;
   logic [2:0]           len_q, len_d;
   logic                 dir_wr_q, dir_wr_d;
   logic [ADDR_BITS-1:0] addr_q, addr_d;
   logic [15:0]          rdata_q, rdata_d;
   logic                 err_q, err_d;
   logic [15:0]          mem_q [DEPTH];

   logic accept;
   logic final_beat;
   logic mem_we;

   assign accept     = (state_q == S_IDLE) && (memread ^ memwrite);
   assign final_beat = (beat_q == len_q);
   assign mem_we     = (state_q == S_XFER) && dir_wr_q;

   if (ADDR_BITS < 16) begin : g_unused_addr
      logic unused_addr_hi;
      assign unused_addr_hi = ^addr[15:ADDR_BITS];
   end

   always_ff @(posedge clk or negedge proc_rst) begin
      if (!proc_rst) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (accept) state_d = (WAIT_STATES == 0) ? S_XFER : S_WAIT;
         end
         S_WAIT: begin
            if (wait_cnt_q == 3'd0) state_d = S_XFER;
         end
         S_XFER: begin
            if (final_beat) state_d = S_IDLE;
            else            state_d = (WAIT_STATES == 0) ? S_XFER : S_WAIT;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      ready       = (state_q == S_IDLE);
      beat_ack    = (state_q == S_XFER);
      last        = beat_ack && final_beat;
      rdata_valid = beat_ack && !dir_wr_q;
      rdata       = rdata_q;
      err         = err_q;
   end

   // Read data is fetched at the address the next XFER will use, so it is registered on the edge entering XFER.
   always_comb begin
      wait_cnt_d = wait_cnt_q;
      beat_d     = beat_q;
      len_d      = len_q;
      dir_wr_d   = dir_wr_q;
      addr_d     = addr_q;
      rdata_d    = rdata_q;
      err_d      = (state_q == S_IDLE) && memread && memwrite;
      if (accept) begin
         addr_d     = addr[ADDR_BITS-1:0];
         len_d      = burst_len;
         dir_wr_d   = memwrite;
         beat_d     = 3'd0;
         wait_cnt_d = WAIT_LOAD;
      end else if (state_q == S_WAIT) begin
         if (wait_cnt_q != 3'd0) wait_cnt_d = wait_cnt_q - 3'd1;
      end else if ((state_q == S_XFER) && !final_beat) begin
         addr_d     = addr_q + 1'b1;
         beat_d     = beat_q + 3'd1;
         wait_cnt_d = WAIT_LOAD;
      end
      if ((state_d == S_XFER) && !dir_wr_d) rdata_d = mem_q[addr_d];
   end

   always_ff @(posedge clk or negedge proc_rst) begin
      if (!proc_rst) begin
         wait_cnt_q <= 3'd0;
         beat_q     <= 3'd0;
         len_q      <= 3'd0;
         dir_wr_q   <= 1'b0;
         addr_q     <= '0;
         rdata_q    <= 16'h0000;
         err_q      <= 1'b0;
      end else begin
         wait_cnt_q <= wait_cnt_d;
         beat_q     <= beat_d;
         len_q      <= len_d;
         dir_wr_q   <= dir_wr_d;
         addr_q     <= addr_d;
         rdata_q    <= rdata_d;
         err_q      <= err_d;
      end
   end

   // Array contents survive reset; a reset mid-beat leaves state_q in IDLE so the pending write is dropped.
   always_ff @(posedge clk) begin
      if (mem_we) mem_q[addr_q] <= mem_wdata;
   end

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: two instances (WAIT_STATES=0 and 1) driven with directed and random
// bursts, checked cycle by cycle against a timing/array reference model.
module tb_mem_responder;

   logic        clk;
   logic        proc_rst;
   logic [1:0]  memread;
   logic [1:0]  memwrite;
   logic [15:0] addr [2];
   logic [15:0] mem_wdata [2];
   logic [2:0]  burst_len [2];
   logic [1:0]  ready;
   logic [1:0]  beat_ack;
   logic [1:0]  last;
   logic [15:0] rdata [2];
   logic [1:0]  rdata_valid;
   logic [1:0]  err;

   int checks = 0;
   int errors = 0;

   logic [15:0] ref_mem [2][256];
   logic [15:0] last_rd [2];
   logic [15:0] wbuf [8];

   for (genvar g = 0; g < 2; g++) begin : g_dut
      mem_responder #(.WAIT_STATES(g), .ADDR_BITS(8)) u_dut (
         .clk        (clk),
         .proc_rst   (proc_rst),
         .memread    (memread[g]),
         .memwrite   (memwrite[g]),
         .addr       (addr[g]),
         .mem_wdata  (mem_wdata[g]),
         .burst_len  (burst_len[g]),
         .ready      (ready[g]),
         .beat_ack   (beat_ack[g]),
         .last       (last[g]),
         .rdata      (rdata[g]),
         .rdata_valid(rdata_valid[g]),
         .err        (err[g])
      );
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk1(input string tag, input int d, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s[d%0d]: observed %b expected %b", tag, d, obs, exp);
      end
   endtask

   task automatic chk16(input string tag, input int d, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s[d%0d]: observed %h expected %h", tag, d, obs, exp);
      end
   endtask

   task automatic chk_reset_vals(input int d);
      chk1("rst_ready", d, ready[d], 1'b1);
      chk1("rst_beat_ack", d, beat_ack[d], 1'b0);
      chk1("rst_last", d, last[d], 1'b0);
      chk1("rst_rdata_valid", d, rdata_valid[d], 1'b0);
      chk1("rst_err", d, err[d], 1'b0);
      chk16("rst_rdata", d, rdata[d], 16'h0000);
   endtask

   task automatic idle_inputs(input int d);
      memread[d]  = 1'b0;
      memwrite[d] = 1'b0;
   endtask

   // One request on instance d (WAIT_STATES = d); expected timing comes from beat period d+1.
   task automatic burst(input int d, input bit wr, input logic [15:0] a, input int len,
                        input bit noise, input int abort_beat);
      int  per, n, beat;
      bit  xfer;
      logic [7:0] ba;
      per = d + 1;
      n   = (len + 1) * per;
      chk1("ready_pre", d, ready[d], 1'b1);
      memread[d]   = !wr;
      memwrite[d]  = wr;
      addr[d]      = a;
      burst_len[d] = 3'(len);
      mem_wdata[d] = wbuf[0];
      for (int c = 1; c <= n; c++) begin
         @(posedge clk); #1;
         xfer = ((c % per) == 0);
         beat = (c - 1) / per;
         ba   = a[7:0] + 8'(beat);
         if (noise) begin
            memread[d]   = 1'($urandom);
            memwrite[d]  = 1'($urandom);
            addr[d]      = 16'($urandom);
            burst_len[d] = 3'($urandom);
         end else begin
            idle_inputs(d);
         end
         mem_wdata[d] = xfer ? wbuf[beat] : 16'($urandom);
         chk1("ready", d, ready[d], 1'b0);
         chk1("beat_ack", d, beat_ack[d], xfer);
         chk1("last", d, last[d], xfer && (beat == len));
         chk1("rdata_valid", d, rdata_valid[d], xfer && !wr);
         chk1("err_busy", d, err[d], 1'b0);
         if (xfer && !wr) last_rd[d] = ref_mem[d][ba];
         chk16("rdata", d, rdata[d], last_rd[d]);
         if (xfer && (beat == abort_beat)) begin
            proc_rst = 1'b0;
            #1;
            chk_reset_vals(d);
            last_rd[0] = 16'h0000;
            last_rd[1] = 16'h0000;
            idle_inputs(d);
            @(posedge clk); #1;
            proc_rst = 1'b1;
            return;
         end
         if (xfer && wr) ref_mem[d][ba] = wbuf[beat];
      end
      @(posedge clk); #1;
      idle_inputs(d);
      chk1("ready_post", d, ready[d], 1'b1);
      chk1("beat_ack_post", d, beat_ack[d], 1'b0);
      chk1("rdata_valid_post", d, rdata_valid[d], 1'b0);
      chk16("rdata_hold", d, rdata[d], last_rd[d]);
   endtask

   task automatic illegal_req(input int d, input logic [15:0] a);
      memread[d]   = 1'b1;
      memwrite[d]  = 1'b1;
      addr[d]      = a;
      burst_len[d] = 3'($urandom);
      mem_wdata[d] = 16'($urandom);
      @(posedge clk); #1;
      idle_inputs(d);
      chk1("err_pulse", d, err[d], 1'b1);
      chk1("err_ready", d, ready[d], 1'b1);
      chk1("err_beat_ack", d, beat_ack[d], 1'b0);
      @(posedge clk); #1;
      chk1("err_clear", d, err[d], 1'b0);
      chk1("err_ready2", d, ready[d], 1'b1);
   endtask

   task automatic rand_wbuf();
      for (int i = 0; i < 8; i++) wbuf[i] = 16'($urandom);
   endtask

   initial begin
      proc_rst = 1'b1;
      for (int d = 0; d < 2; d++) begin
         idle_inputs(d);
         addr[d]      = 16'h0000;
         mem_wdata[d] = 16'h0000;
         burst_len[d] = 3'd0;
         last_rd[d]   = 16'h0000;
      end
      #1 proc_rst = 1'b0;
      #2;
      chk_reset_vals(0);
      chk_reset_vals(1);
      repeat (2) @(posedge clk);
      #1;
      chk_reset_vals(0);
      chk_reset_vals(1);
      proc_rst = 1'b1;

      // Give both arrays known contents before any read.
      for (int d = 0; d < 2; d++) begin
         for (int blk = 0; blk < 32; blk++) begin
            rand_wbuf();
            burst(d, 1'b1, 16'(blk * 8), 7, 1'b0, -1);
         end
      end

      wbuf[0] = 16'hABCD;
      burst(1, 1'b1, 16'h0005, 0, 1'b0, -1);
      burst(1, 1'b0, 16'h0005, 0, 1'b0, -1);
      chk16("rd_abcd", 1, rdata[1], 16'hABCD);

      for (int i = 0; i < 8; i++) wbuf[i] = 16'h1000 + 16'(i);
      burst(0, 1'b1, 16'h00FE, 7, 1'b0, -1);
      burst(0, 1'b0, 16'h00FE, 7, 1'b0, -1);
      chk16("rd_wrap_last", 0, rdata[0], 16'h1007);
      burst(0, 1'b0, 16'h0000, 0, 1'b0, -1);
      chk16("rd_wrap_0000", 0, rdata[0], 16'h1002);

      illegal_req(1, 16'h0005);
      burst(1, 1'b0, 16'h0005, 0, 1'b0, -1);
      chk16("rd_after_err", 1, rdata[1], 16'hABCD);
      illegal_req(0, 16'h00FF);
      burst(0, 1'b0, 16'h00FF, 0, 1'b0, -1);
      chk16("rd_after_err", 0, rdata[0], 16'h1001);

      burst(1, 1'b0, 16'h0030, 3, 1'b1, -1);
      burst(0, 1'b0, 16'h0031, 3, 1'b1, -1);

      for (int d = 0; d < 2; d++) begin
         for (int it = 0; it < 25; it++) begin
            rand_wbuf();
            burst(d, 1'($urandom), 16'($urandom), int'($urandom_range(0, 7)), 1'($urandom), -1);
         end
      end

      rand_wbuf();
      burst(1, 1'b1, 16'h0040, 7, 1'b0, 2);
      burst(1, 1'b0, 16'h0040, 7, 1'b0, -1);
      chk16("abort_rd_last", 1, rdata[1], ref_mem[1][8'h47]);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 The block SHALL have parameter WAIT_STATES, default 1, giving idle cycles inserted before each beat (legal range 0..7).
REQ-002 The block SHALL have parameter ADDR_BITS, default 8, giving the internal array depth of 2^ADDR_BITS 16-bit words.
REQ-003 The block SHALL have port clk  in  1  single system clock; all state changes occur on its rising edge.
REQ-004 The block SHALL have port proc_rst  in  1  reset, asynchronous and active-low.
REQ-005 The block SHALL have port memread  in  1  read request, sampled in IDLE.
REQ-006 The block SHALL have port memwrite  in  1  write request, sampled in IDLE.
REQ-007 The block SHALL have port addr  in  16  start word address; only the low ADDR_BITS bits are used.
REQ-008 The block SHALL have port mem_wdata  in  16  write data, sampled in every write XFER cycle.
REQ-009 The block SHALL have port burst_len  in  3  number of beats minus 1 (0 = single word, 7 = eight words).
REQ-010 The block SHALL have port ready  out  1  high only in IDLE.
REQ-011 The block SHALL have port beat_ack  out  1  high during every XFER cycle.
REQ-012 The block SHALL have port last  out  1  high during the XFER cycle of the final beat.
REQ-013 The block SHALL have port rdata  out  16  read data, valid while rdata_valid is high.
REQ-014 The block SHALL have port rdata_valid  out  1  high during a read XFER cycle.
REQ-015 The block SHALL have port err  out  1  one-cycle pulse on an illegal request.

Function
REQ-016 The state machine SHALL have the states IDLE, WAIT and XFER.
REQ-017 In IDLE, exactly one of memread/memwrite high at a rising edge SHALL accept the request: latch addr, burst_len and direction, load the beat counter with 0, and go to WAIT (or to XFER if WAIT_STATES=0).
REQ-018 WAIT SHALL last exactly WAIT_STATES cycles, then the block SHALL go to XFER.
REQ-019 XFER SHALL last exactly one cycle.
REQ-020 Each beat SHALL therefore take WAIT_STATES+1 cycles, and a request SHALL keep ready low for (burst_len+1)*(WAIT_STATES+1) cycles after the accepting edge.
REQ-021 For a read, rdata SHALL be registered from array[cur_addr] on the edge entering XFER, and rdata_valid SHALL be high only during XFER.
REQ-022 For a write, array[cur_addr] SHALL be written with mem_wdata on the edge leaving XFER; rdata_valid SHALL stay low.
REQ-023 On leaving XFER with beats remaining, cur_addr SHALL increment modulo 2^ADDR_BITS (wrap-around, no error) and the block SHALL return to WAIT (or to XFER if WAIT_STATES=0).
REQ-024 On leaving XFER after the final beat (beat counter equal to latched burst_len), the block SHALL return to IDLE.
REQ-025 last SHALL equal beat_ack AND (beat counter = latched burst_len).
REQ-026 memread and memwrite both high in IDLE SHALL be rejected: err pulses high for one cycle, the state stays IDLE, and the array is unchanged.
REQ-027 memread, memwrite, addr and burst_len SHALL be ignored outside IDLE; there is no queuing.
REQ-028 The requester SHALL present the next write word after seeing beat_ack; the block SHALL not buffer write data.
REQ-029 Between reads, rdata SHALL hold its last value.

Reset
REQ-030 While proc_rst=0, the block SHALL immediately (asynchronously) enter IDLE and drive ready=1, beat_ack=0, last=0, rdata_valid=0, err=0 and rdata=16'h0000.
REQ-031 Reset SHALL clear the beat counter and latched request; array contents SHALL NOT be reset.
REQ-032 Reset asserted mid-burst SHALL abort the burst; words already written SHALL be retained and the in-flight beat SHALL NOT be written.
REQ-033 The first request SHALL be accepted on the first rising edge after proc_rst returns to 1.

Verification
REQ-034 WAIT_STATES=1: write 16'hABCD to addr 16'h0005 with burst_len=0, then read 16'h0005 -> rdata=16'hABCD, rdata_valid and last high in the 2nd cycle after acceptance, ready back high in the 3rd cycle.
REQ-035 WAIT_STATES=0: burst write with burst_len=7 at addr 16'h00FE, data 16'h1000..16'h1007 -> eight consecutive beat_ack cycles, last on the 8th; reading back 16'h00FE, 16'h00FF, 16'h0000..16'h0005 returns 16'h1000..16'h1007.
REQ-036 memread=memwrite=1 in IDLE -> err=1 for exactly one cycle, ready stays 1, and a following read of the target address returns its previous contents.
REQ-037 New request driven during a burst read of burst_len=3 -> ignored; exactly 4 beats occur and then IDLE.
REQ-038 proc_rst driven low during beat 3 of an 8-beat write -> all outputs take their reset values immediately; readback shows beats 1-2 written and beats 3-8 unchanged.
